// File: rtl/active_lamps_ramp_pkg.sv
// Shared definitions for the lamp ramp controller: time-code constants and ramp state encoding.
package active_lamps_ramp_pkg;

  localparam logic [3:0] TcOff0   = 4'b0000;
  localparam logic [3:0] TcOffNow = 4'b0001;
  localparam logic [3:0] TcOff2   = 4'b0010;
  localparam logic [3:0] TcRoom   = 4'b0100;
  localparam logic [3:0] TcUser   = 4'b1000;

  typedef enum logic [1:0] {
    StSettled  = 2'd0,
    StRampUp   = 2'd1,
    StRampDown = 2'd2
  } ramp_state_e;

endpackage

// File: rtl/active_lamps_ramp_channel.sv
// One room: decodes the time code into a clamped target and walks the lamp count toward it
// one lamp per prescaler tick.
module active_lamps_ramp_channel
  import active_lamps_ramp_pkg::*;
#(
  parameter int unsigned WIDTH     = 4,
  parameter int unsigned MAX_LAMPS = 15
) (
  input  logic             i_clk,
  input  logic             i_rst,
  input  logic             i_tick,
  input  logic             i_load,
  input  logic [3:0]       i_tcode,
  input  logic [WIDTH-1:0] i_ulight,
  input  logic [WIDTH-1:0] i_length,
  output logic [WIDTH-1:0] o_count,
  output logic             o_settled
);

  localparam logic [WIDTH-1:0] MaxLamps = WIDTH'(MAX_LAMPS);

  ramp_state_e      r_state, w_state_d;
  logic [WIDTH-1:0] r_count, w_count_d;
  logic [WIDTH-1:0] r_target, w_target_d;
  logic [WIDTH-1:0] w_decoded;
  logic             w_off_now;

  always_comb begin
    w_decoded = '0;
    w_off_now = 1'b0;
    case (i_tcode)
      TcUser:         w_decoded = i_ulight;
      TcRoom:         w_decoded = i_length >> 2;
      TcOffNow:       w_off_now = 1'b1;
      TcOff0, TcOff2: w_decoded = '0;
      default:        w_decoded = '0;
    endcase
  end

  // The step uses the pre-load state, so a load on a tick edge retargets only from the next tick.
  always_comb begin
    w_target_d = r_target;
    w_count_d  = r_count;
    if (i_tick) begin
      if (r_state == StRampUp) begin
        w_count_d = r_count + 1'b1;
      end else if (r_state == StRampDown) begin
        w_count_d = r_count - 1'b1;
      end
    end
    if (i_load) begin
      w_target_d = (w_decoded > MaxLamps) ? MaxLamps : w_decoded;
      if (w_off_now) begin
        w_target_d = '0;
        w_count_d  = '0;
      end
    end
  end

  always_comb begin
    if (w_count_d == w_target_d) begin
      w_state_d = StSettled;
    end else if (w_count_d < w_target_d) begin
      w_state_d = StRampUp;
    end else begin
      w_state_d = StRampDown;
    end
  end

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_state <= StSettled;
    end else begin
      r_state <= w_state_d;
    end
  end

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_count  <= '0;
      r_target <= '0;
    end else begin
      r_count  <= w_count_d;
      r_target <= w_target_d;
    end
  end

  always_comb begin
    o_count   = r_count;
    o_settled = (r_state == StSettled);
  end

endmodule

// File: rtl/active_lamps_ramp.sv
// Multi-room soft on/off lamp controller: shared ramp prescaler feeding one channel per room.
module active_lamps_ramp #(
  parameter int unsigned CHANNELS  = 4,
  parameter int unsigned WIDTH     = 4,
  parameter int unsigned MAX_LAMPS = 15,
  parameter int unsigned RAMP_DIV  = 8
) (
  input  logic                      i_clk,
  input  logic                      i_rst,
  input  logic [CHANNELS-1:0]       i_load,
  input  logic [4*CHANNELS-1:0]     i_tcode,
  input  logic [WIDTH*CHANNELS-1:0] i_ulight,
  input  logic [WIDTH*CHANNELS-1:0] i_length,
  output logic [WIDTH*CHANNELS-1:0] o_active_lights,
  output logic [CHANNELS-1:0]       o_settled,
  output logic                      o_busy
);

  // Keep at least one bit so RAMP_DIV=1 still elaborates; the counter then sits at 0.
  localparam int unsigned       PrescW    = (RAMP_DIV > 1) ? $clog2(RAMP_DIV) : 1;
  localparam logic [PrescW-1:0] PrescLast = PrescW'(RAMP_DIV - 1);

  logic [PrescW-1:0]   r_presc;
  logic                w_tick;
  logic [CHANNELS-1:0] w_settled;

  assign w_tick = (r_presc == PrescLast);

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_presc <= '0;
    end else if (w_tick) begin
      r_presc <= '0;
    end else begin
      r_presc <= r_presc + 1'b1;
    end
  end

  for (genvar g = 0; g < CHANNELS; g++) begin : g_chan
    active_lamps_ramp_channel #(
      .WIDTH     (WIDTH),
      .MAX_LAMPS (MAX_LAMPS)
    ) u_chan (
      .i_clk     (i_clk),
      .i_rst     (i_rst),
      .i_tick    (w_tick),
      .i_load    (i_load[g]),
      .i_tcode   (i_tcode[4*g +: 4]),
      .i_ulight  (i_ulight[WIDTH*g +: WIDTH]),
      .i_length  (i_length[WIDTH*g +: WIDTH]),
      .o_count   (o_active_lights[WIDTH*g +: WIDTH]),
      .o_settled (w_settled[g])
    );
  end

  always_comb begin
    o_settled = w_settled;
    o_busy    = |(~w_settled);
  end

endmodule

// File: tb/tb_active_lamps_ramp.sv
// Directed vector bench for active_lamps_ramp with two rooms and a 4-cycle ramp step.
module tb_active_lamps_ramp;

  localparam int unsigned CHANNELS  = 2;
  localparam int unsigned WIDTH     = 4;
  localparam int unsigned MAX_LAMPS = 15;
  localparam int unsigned RAMP_DIV  = 4;

  logic       clk;
  logic       rst;
  logic [1:0] load;
  logic [7:0] tcode;
  logic [7:0] ulight;
  logic [7:0] length;
  logic [7:0] active;
  logic [1:0] settled;
  logic       busy;

  int n_checks;
  int n_errors;

  typedef struct {
    logic       rst;
    logic [1:0] load;
    logic [7:0] tcode;
    logic [7:0] ulight;
    logic [7:0] length;
    int         ncyc;
    logic [7:0] exp_act;
    logic [1:0] exp_set;
    logic       exp_busy;
  } vec_t;

  vec_t vecs[$];

  active_lamps_ramp #(
    .CHANNELS  (CHANNELS),
    .WIDTH     (WIDTH),
    .MAX_LAMPS (MAX_LAMPS),
    .RAMP_DIV  (RAMP_DIV)
  ) dut (
    .i_clk           (clk),
    .i_rst           (rst),
    .i_load          (load),
    .i_tcode         (tcode),
    .i_ulight        (ulight),
    .i_length        (length),
    .o_active_lights (active),
    .o_settled       (settled),
    .o_busy          (busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic add(input logic r, input logic [1:0] ld, input logic [7:0] tc,
                     input logic [7:0] ul, input logic [7:0] ln, input int nc,
                     input logic [7:0] ea, input logic [1:0] es, input logic eb);
    vec_t v;
    v.rst = r; v.load = ld; v.tcode = tc; v.ulight = ul; v.length = ln; v.ncyc = nc;
    v.exp_act = ea; v.exp_set = es; v.exp_busy = eb;
    vecs.push_back(v);
  endtask

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic tick_clk();
    @(posedge clk);
    #1;
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish, got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int n;
    n_checks = 0;
    n_errors = 0;
    rst = 1'b1; load = 2'b00; tcode = 8'h00; ulight = 8'h00; length = 8'h00;

    // Idle rows (load=0) advance time; prescaler phase noted as p after each row.
    add(1, 2'b11, 8'h88, 8'h99, 8'hFF, 2,  8'h00, 2'b11, 0); // reset, p=0
    add(0, 2'b01, 8'h08, 8'h05, 8'h00, 1,  8'h00, 2'b10, 1); // ch0 -> 5, p=1
    add(0, 2'b00, 8'h00, 8'h00, 8'h00, 2,  8'h00, 2'b10, 1); // p=3
    add(0, 2'b00, 8'h00, 8'h00, 8'h00, 1,  8'h01, 2'b10, 1);
    add(0, 2'b00, 8'h00, 8'h00, 8'h00, 4,  8'h02, 2'b10, 1);
    add(0, 2'b00, 8'h00, 8'h00, 8'h00, 4,  8'h03, 2'b10, 1);
    add(0, 2'b00, 8'h00, 8'h00, 8'h00, 3,  8'h03, 2'b10, 1); // p=3
    add(0, 2'b00, 8'h00, 8'h00, 8'h00, 1,  8'h04, 2'b10, 1);
    add(0, 2'b00, 8'h00, 8'h00, 8'h00, 4,  8'h05, 2'b11, 0);
    add(0, 2'b10, 8'h40, 8'h00, 8'hD0, 1,  8'h05, 2'b01, 1); // ch1 13>>2=3
    add(0, 2'b00, 8'h00, 8'h00, 8'h00, 3,  8'h15, 2'b01, 1);
    add(0, 2'b00, 8'h00, 8'h00, 8'h00, 8,  8'h35, 2'b11, 0);
    add(0, 2'b10, 8'h40, 8'h00, 8'hF0, 1,  8'h35, 2'b11, 0); // 15>>2=3, no change
    add(0, 2'b00, 8'h00, 8'h00, 8'h00, 7,  8'h35, 2'b11, 0);
    add(0, 2'b01, 8'h01, 8'h00, 8'h00, 1,  8'h30, 2'b11, 0); // off now from 5
    add(0, 2'b01, 8'h08, 8'h05, 8'h00, 1,  8'h30, 2'b10, 1); // p=2
    add(0, 2'b00, 8'h00, 8'h00, 8'h00, 2,  8'h31, 2'b10, 1);
    add(0, 2'b00, 8'h00, 8'h00, 8'h00, 8,  8'h33, 2'b10, 1);
    add(0, 2'b01, 8'h08, 8'h01, 8'h00, 1,  8'h33, 2'b10, 1); // retarget down at 3
    add(0, 2'b00, 8'h00, 8'h00, 8'h00, 3,  8'h32, 2'b10, 1);
    add(0, 2'b00, 8'h00, 8'h00, 8'h00, 4,  8'h31, 2'b11, 0);
    add(0, 2'b01, 8'h08, 8'h05, 8'h00, 1,  8'h31, 2'b10, 1);
    add(0, 2'b00, 8'h00, 8'h00, 8'h00, 3,  8'h32, 2'b10, 1);
    add(0, 2'b00, 8'h00, 8'h00, 8'h00, 4,  8'h33, 2'b10, 1);
    add(0, 2'b00, 8'h00, 8'h00, 8'h00, 3,  8'h33, 2'b10, 1); // p=3
    add(0, 2'b01, 8'h08, 8'h01, 8'h00, 1,  8'h34, 2'b10, 1); // load on tick: old step
    add(0, 2'b00, 8'h00, 8'h00, 8'h00, 4,  8'h33, 2'b10, 1);
    add(0, 2'b00, 8'h00, 8'h00, 8'h00, 4,  8'h32, 2'b10, 1);
    add(0, 2'b00, 8'h00, 8'h00, 8'h00, 4,  8'h31, 2'b11, 0);
    add(0, 2'b01, 8'h08, 8'h04, 8'h00, 1,  8'h31, 2'b10, 1);
    add(0, 2'b00, 8'h00, 8'h00, 8'h00, 3,  8'h32, 2'b10, 1);
    add(0, 2'b00, 8'h00, 8'h00, 8'h00, 4,  8'h33, 2'b10, 1);
    add(0, 2'b00, 8'h00, 8'h00, 8'h00, 4,  8'h34, 2'b11, 0);
    add(0, 2'b01, 8'h03, 8'h00, 8'h00, 1,  8'h34, 2'b10, 1); // 0011 ramps to 0
    add(0, 2'b00, 8'h00, 8'h00, 8'h00, 3,  8'h33, 2'b10, 1);
    add(0, 2'b00, 8'h00, 8'h00, 8'h00, 12, 8'h30, 2'b11, 0);
    add(0, 2'b01, 8'h08, 8'h04, 8'h00, 1,  8'h30, 2'b10, 1);
    add(0, 2'b00, 8'h00, 8'h00, 8'h00, 3,  8'h31, 2'b10, 1);
    add(0, 2'b00, 8'h00, 8'h00, 8'h00, 12, 8'h34, 2'b11, 0);
    add(0, 2'b01, 8'h01, 8'h00, 8'h00, 1,  8'h30, 2'b11, 0); // off now at 4
    add(0, 2'b01, 8'h08, 8'h05, 8'h00, 1,  8'h30, 2'b10, 1); // p=2
    add(0, 2'b00, 8'h00, 8'h00, 8'h00, 2,  8'h31, 2'b10, 1);
    add(0, 2'b00, 8'h00, 8'h00, 8'h00, 3,  8'h31, 2'b10, 1); // p=3
    add(0, 2'b01, 8'h01, 8'h00, 8'h00, 1,  8'h30, 2'b11, 0); // off wins over tick
    add(0, 2'b01, 8'h08, 8'h05, 8'h00, 1,  8'h30, 2'b10, 1);
    add(0, 2'b00, 8'h00, 8'h00, 8'h00, 3,  8'h31, 2'b10, 1);
    add(0, 2'b00, 8'h00, 8'h00, 8'h00, 4,  8'h32, 2'b10, 1);
    add(1, 2'b11, 8'h48, 8'h0F, 8'hFF, 1,  8'h00, 2'b11, 0); // reset + load mid-ramp
    add(0, 2'b00, 8'h00, 8'h00, 8'h00, 8,  8'h00, 2'b11, 0);
    add(0, 2'b11, 8'h88, 8'h33, 8'h00, 1,  8'h00, 2'b00, 1);
    add(0, 2'b00, 8'h00, 8'h00, 8'h00, 15, 8'h33, 2'b11, 0);
    add(0, 2'b11, 8'h20, 8'h00, 8'h00, 1,  8'h33, 2'b00, 1); // 0000 / 0010 ramp down
    add(0, 2'b00, 8'h00, 8'h00, 8'h00, 3,  8'h22, 2'b00, 1);
    add(0, 2'b00, 8'h00, 8'h00, 8'h00, 8,  8'h00, 2'b11, 0);

    foreach (vecs[i]) begin
      for (int c = 0; c < vecs[i].ncyc; c++) begin
        rst    = vecs[i].rst;
        load   = (c == 0) ? vecs[i].load : 2'b00;
        tcode  = vecs[i].tcode;
        ulight = vecs[i].ulight;
        length = vecs[i].length;
        tick_clk();
      end
      check($sformatf("v%0d_active", i), 32'(active), 32'(vecs[i].exp_act));
      check($sformatf("v%0d_settled", i), 32'(settled), 32'(vecs[i].exp_set));
      check($sformatf("v%0d_busy", i), 32'(busy), 32'(vecs[i].exp_busy));
    end

    // Ramp 0->2 from prescaler phase 0: ticks land on the 3rd and 7th edge after the load.
    rst = 1'b0; load = 2'b01; tcode = 8'h08; ulight = 8'h02;
    tick_clk();
    load = 2'b00;
    check("ramp2_started", 32'(settled[0]), 32'd0);
    n = 0;
    while (settled[0] !== 1'b1 && n < 20) begin
      tick_clk();
      n++;
    end
    check("ramp2_edges", 32'(n), 32'd7);
    check("ramp2_active", 32'(active), 32'h02);
    check("ramp2_busy", 32'(busy), 32'd0);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule

// File: doc/active_lamps_ramp.md
# active_lamps_ramp

Multi-channel, parametrised lamp controller that computes a target number of active lamps per room from a one-hot time code, user light level and room length. It drives the registered active-lamp count toward that target one lamp per prescaler tick (soft on/soft off), and supports an immediate-off mode. It sits between the room/time-code decoding logic and the lamp driver outputs, replacing the single-room combinational lamp-count stage.

## Interface
- `CHANNELS`, 4: number of rooms/channels.
- `WIDTH`, 4: bit width of ulight, length and lamp count per channel.
- `MAX_LAMPS`, 15: upper clamp on any target (must be ≤ 2^WIDTH−1).
- `RAMP_DIV`, 8: clock cycles per ramp step (≥1).
- `clk`, in, 1: single clock, rising edge.
- `rst`, in, 1: synchronous, active-high reset.
- `load`, in, CHANNELS: per-channel strobe; samples that channel's tcode/ulight/length.
- `tcode`, in, 4*CHANNELS: per-channel time code, channel i at [4i+:4].
- `ulight`, in, WIDTH*CHANNELS: per-channel user light level, channel i at [WIDTH*i+:WIDTH].
- `length`, in, WIDTH*CHANNELS: per-channel square-room length, same packing.
- `active_lights`, out, WIDTH*CHANNELS: registered current lamp count per channel.
- `settled`, out, CHANNELS: channel count equals its target.
- `busy`, out, 1: OR of ~settled.

## Operation
- Target decode on load, per channel:
  - tcode 4'b1000 gives ulight.
  - tcode 4'b0100 gives length>>2.
  - tcode 4'b0001 is immediate off.
  - tcode 4'b0000, 4'b0010 and any other code give target 0, reached by ramping.
- Target is min(decoded, MAX_LAMPS). Target register holds between loads.
- Prescaler: one shared free-running counter 0..RAMP_DIV−1. `tick` is asserted when the count equals RAMP_DIV−1, and the counter then wraps to 0. With RAMP_DIV=1, tick is asserted every cycle. `load` never resets the prescaler.
- Per-channel state (registered): SETTLED, RAMP_UP, RAMP_DOWN.
  - On tick in RAMP_UP: count+1. In RAMP_DOWN: count−1. Step size is always 1, with no overshoot.
  - State is recomputed every cycle from the next count versus the next target: equal gives SETTLED, less gives RAMP_UP, greater gives RAMP_DOWN.
- Immediate off: on the load edge, count and target both become 0 and the state becomes SETTLED, regardless of the current ramp.
- Retarget mid-ramp: a new load takes effect from the current count with no jump. Direction may reverse.
- Arithmetic: count never exceeds MAX_LAMPS and never goes below 0 (guaranteed by the compare). No wrap-around.
- `settled[i]` = (state==SETTLED). `busy` = |~settled.

## Timing
- Reset (sync, at a clk edge with rst=1): active_lights=0, targets=0, prescaler=0, state=SETTLED, settled=all 1, busy=0. Reset overrides load and tick in the same cycle, including mid-ramp.
- Load sampled at edge n: the target is visible internally after edge n. settled/busy reflect the new target after edge n (one cycle latency).
- First step occurs on the first tick edge strictly after edge n.
- Load and tick on the same edge: the step uses the old target and state; the new target applies from the next tick.
- Immediate off: active_lights=0 after edge n.
- Ramp of k lamps takes k ticks, i.e. about k*RAMP_DIV cycles plus a prescaler-phase offset of 0..RAMP_DIV−1.
- All outputs are registered or derived from registers only. There are no input-to-output combinational paths.

## Structure
- Shared include/package `lamp_defs`: tcode constants (TC_OFF0=4'b0000, TC_OFF_NOW=4'b0001, TC_OFF2=4'b0010, TC_ROOM=4'b0100, TC_USER=4'b1000) and the ramp state encoding (SETTLED/RAMP_UP/RAMP_DOWN, 2 bits).
- Sub-module `lamp_channel`: target decode, clamp, target register, state register and count register for one channel. It takes `tick` as an input.
- Top `active_lamps_ramp`: prescaler, generate loop over CHANNELS, busy OR-reduce.

## Test plan
Configuration for all scenarios: CHANNELS=2, WIDTH=4, MAX_LAMPS=15, RAMP_DIV=4.
- Reset: hold rst for 2 cycles with random inputs -> active_lights=0, settled=2'b11, busy=0.
- Ch0 load, tcode 1000, ulight 5 -> settled[0]=0 the next cycle; count steps 0,1,…,5, one per 4 cycles; settled[0]=1 and busy=0 when the count reaches 5. Ch1 stays 0.
- Ch1 load, tcode 0100, length 13 -> target 3 (13>>2); count reaches 3 after 3 ticks. Length 4'b1111 -> 3.
- Ch0 ramping up at count 3 toward 5, load ulight 1 -> next ticks give 2 then 1 with no jump; load coinciding with a tick steps to 4 first.
- Ch0 at count 4, load tcode 0001 -> active_lights[0]=0 after that edge, settled[0]=1. Same at count 4 with tcode 0011 -> ramps 4→0 over 4 ticks.
- rst asserted mid-ramp (count 2→5) together with load -> all counts 0 after that edge, load ignored, busy=0.
